cam_pixel_assembler: RTL and testbench
======================================

# cam_pixel_assembler

Camera-side front end of the capture path. Samples the 8-bit camera bus on `pclk` under `VSYNC`/`HREF`, pairs RGB565 bytes into one 12-bit RGB444 pixel, and presents it with a one-cycle `Wrtcmplt` strobe, pixel coordinates and frame/line markers to the downstream pixel-bus consumer and serial transmitter.

## Interface
Parameters:
- `H_PIXELS`, 640, pixels per line accepted; extra bytes in a line are dropped.
- `V_LINES`, 480, lines per frame accepted; extra lines are dropped.
- `XW`, 10, width of `pix_x`.
- `YW`, 9, width of `pix_y`.

Ports:
- `pclk` in 1: camera pixel clock, the only clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `VSYNC` in 1: high during vertical blanking; falling edge starts a frame.
- `HREF` in 1: high while line bytes are valid.
- `pshdta` in 8: camera data byte.
- `PixParaBus` out 12: assembled pixel {R[3:0],G[3:0],B[3:0]}.
- `Wrtcmplt` out 1: one-cycle strobe, `PixParaBus`/`pix_x`/`pix_y` valid.
- `pix_x` out XW: column of presented pixel.
- `pix_y` out YW: line of presented pixel.
- `frame_start` out 1: one-cycle pulse after VSYNC falling edge.
- `line_end` out 1: one-cycle pulse after HREF falling edge of an accepted line.
- `frame_err` out 1: sticky framing error, cleared on `frame_start`.

## Operation
- Reset: all outputs 0, byte latch 0, counters 0, state SYNC.
- States: SYNC (wait VSYNC high), BLANK (VSYNC high, wait fall), LINE_WAIT (HREF low), BYTE_HI, BYTE_LO.
- SYNC -> BLANK when VSYNC=1. Reset mid-frame therefore discards the rest of that frame.
- BLANK -> LINE_WAIT on VSYNC=0; `frame_start`=1, `frame_err`=0, x/y counters=0.
- VSYNC=1 in LINE_WAIT/BYTE_HI/BYTE_LO -> BLANK immediately; pending byte discarded, no strobe; if in BYTE_LO, `frame_err`=1.
- LINE_WAIT -> BYTE_HI when HREF=1. The same edge samples the first byte: state acts as "expect high byte".
- BYTE_HI with HREF=1: latch `pshdta` as b1, go BYTE_LO.
- BYTE_LO with HREF=1: with b2=`pshdta`, `PixParaBus` <= {b1[7:4], b1[2:0], b2[7], b2[4:1]} (RGB565 R[4:1], G[5:2], B[4:1]), `Wrtcmplt` <= 1, `pix_x` <= x, `pix_y` <= y, x <= x+1, go BYTE_HI.
- Column limit: if x = H_PIXELS at a BYTE_LO completion, no strobe, `frame_err`=1; bytes continue to be consumed and dropped until HREF falls.
- HREF=0 in BYTE_HI/BYTE_LO: line ends. If in BYTE_LO (odd byte count), drop b1, `frame_err`=1. If x>0 then `line_end`=1 and y <= y+1. x <= 0. Go LINE_WAIT.
- Line limit: when y = V_LINES, whole lines are dropped (no strobes, no `line_end`), `frame_err`=1 on the first dropped byte.
- Counter widths: x counts 0..H_PIXELS, y counts 0..V_LINES, no wrap. XW/YW must hold H_PIXELS and V_LINES; not checked.

## Timing
- Byte sampled on the rising `pclk` edge where HREF=1. The second byte's edge registers the pixel; `Wrtcmplt` is high for exactly the following cycle.
- Latency: 1 `pclk` from second-byte edge to valid pixel. Maximum rate: 1 strobe per 2 `pclk`.
- `PixParaBus`, `pix_x` and `pix_y` hold their values until the next strobe.
- `frame_start` is high the cycle after the edge that samples VSYNC=0 in BLANK.
- `line_end` is high the cycle after the edge that samples HREF=0.
- Simultaneous VSYNC rise and HREF fall: VSYNC wins; no `line_end`.
- No internal synchronizers; inputs are assumed to be pclk-synchronous from the camera.

## Test plan
- Reset mid-line, then VSYNC 1->0, HREF high 4 bytes F8,00,07,E0 -> no output before VSYNC high, `frame_start` once, strobes PixParaBus=F00 (x0) then 0F0 (x1), y=0.
- Byte pair 00,1F -> PixParaBus=00F. Byte pair FF,FF -> FFF. Strobes 2 cycles apart with back-to-back bytes.
- H_PIXELS=4, line of 12 bytes -> 4 strobes x=0..3, `frame_err`=1, one `line_end`, next line y=1.
- Line with 5 bytes -> 2 strobes, last byte dropped, `frame_err`=1. Next `frame_start` clears `frame_err` to 0.
- V_LINES=2, 3 lines of 4 bytes -> strobes only with y=0,1, 2 `line_end` pulses, `frame_err`=1.
- VSYNC rises during BYTE_LO -> no strobe, `frame_err`=1. Next frame starts at x=0, y=0.

Source files
------------

// File: rtl/cam_pixel_assembler.sv
// Camera byte-pair assembler: samples the pclk-synchronous camera bus under VSYNC/HREF,
// converts RGB565 byte pairs to RGB444 pixels and reports coordinates, frame/line markers and framing errors.
module cam_pixel_assembler #(
  parameter int unsigned H_PIXELS = 640,
  parameter int unsigned V_LINES  = 480,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 9
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          VSYNC,
  input  logic          HREF,
  input  logic [7:0]    pshdta,
  output logic [11:0]   PixParaBus,
  output logic          Wrtcmplt,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          frame_start,
  output logic          line_end,
  output logic          frame_err
);

  localparam logic [XW-1:0] X_MAX = XW'(H_PIXELS);
  localparam logic [YW-1:0] Y_MAX = YW'(V_LINES);

  typedef enum logic [2:0] {
    S_SYNC,
    S_BLANK,
    S_LINE_WAIT,
    S_BYTE_HI,
    S_BYTE_LO
  } state_t;

  state_t        r_state, w_state;
  logic [7:0]    r_b1, w_b1;
  logic [XW-1:0] r_x, w_x;
  logic [YW-1:0] r_y, w_y;
  logic [11:0]   r_pix, w_pix;
  logic [XW-1:0] r_px, w_px;
  logic [YW-1:0] r_py, w_py;
  logic          r_wr, w_wr;
  logic          r_fs, w_fs;
  logic          r_le, w_le;
  logic          r_err, w_err;
  logic          w_y_full;

  assign w_y_full = (r_y == Y_MAX);

  // Next-state and next-output logic; LINE_WAIT doubles as "expect high byte".
  always_comb begin
    w_state = r_state;
    w_b1    = r_b1;
    w_x     = r_x;
    w_y     = r_y;
    w_pix   = r_pix;
    w_px    = r_px;
    w_py    = r_py;
    w_wr    = 1'b0;
    w_fs    = 1'b0;
    w_le    = 1'b0;
    w_err   = r_err;
    case (r_state)
      S_SYNC: begin
        if (VSYNC) w_state = S_BLANK;
      end
      S_BLANK: begin
        if (!VSYNC) begin
          w_state = S_LINE_WAIT;
          w_fs    = 1'b1;
          w_err   = 1'b0;
          w_x     = '0;
          w_y     = '0;
        end
      end
      S_LINE_WAIT, S_BYTE_HI: begin
        if (VSYNC) begin
          w_state = S_BLANK;
        end else if (HREF) begin
          w_b1    = pshdta;
          w_state = S_BYTE_LO;
          if (w_y_full) w_err = 1'b1;
        end else if (r_state == S_BYTE_HI) begin
          if (r_x != '0) begin
            w_le = 1'b1;
            w_y  = r_y + YW'(1);
          end
          w_x     = '0;
          w_state = S_LINE_WAIT;
        end
      end
      S_BYTE_LO: begin
        if (VSYNC) begin
          w_state = S_BLANK;
          w_err   = 1'b1;
        end else if (HREF) begin
          w_state = S_BYTE_HI;
          if (w_y_full || (r_x == X_MAX)) begin
            w_err = 1'b1;
          end else begin
            w_pix = {r_b1[7:4], r_b1[2:0], pshdta[7], pshdta[4:1]};
            w_wr  = 1'b1;
            w_px  = r_x;
            w_py  = r_y;
            w_x   = r_x + XW'(1);
          end
        end else begin
          // Odd byte count: the pending high byte is dropped.
          w_err = 1'b1;
          if (r_x != '0) begin
            w_le = 1'b1;
            w_y  = r_y + YW'(1);
          end
          w_x     = '0;
          w_state = S_LINE_WAIT;
        end
      end
      default: w_state = S_SYNC;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state <= S_SYNC;
      r_b1    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_pix   <= '0;
      r_px    <= '0;
      r_py    <= '0;
      r_wr    <= 1'b0;
      r_fs    <= 1'b0;
      r_le    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_b1    <= w_b1;
      r_x     <= w_x;
      r_y     <= w_y;
      r_pix   <= w_pix;
      r_px    <= w_px;
      r_py    <= w_py;
      r_wr    <= w_wr;
      r_fs    <= w_fs;
      r_le    <= w_le;
      r_err   <= w_err;
    end
  end

  assign PixParaBus  = r_pix;
  assign Wrtcmplt    = r_wr;
  assign pix_x       = r_px;
  assign pix_y       = r_py;
  assign frame_start = r_fs;
  assign line_end    = r_le;
  assign frame_err   = r_err;

endmodule

// File: tb/tb_cam_pixel_assembler.sv
// Directed bench for cam_pixel_assembler with a small frame (4 pixels x 2 lines) to reach the limits quickly.
module tb_cam_pixel_assembler;

  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;

  logic          pclk = 1'b0;
  logic          rst;
  logic          VSYNC;
  logic          HREF;
  logic [7:0]    pshdta;
  logic [11:0]   PixParaBus;
  logic          Wrtcmplt;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          frame_start;
  logic          line_end;
  logic          frame_err;

  int errors = 0;
  int checks = 0;

  cam_pixel_assembler #(
    .H_PIXELS(4),
    .V_LINES (2),
    .XW      (XW),
    .YW      (YW)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .VSYNC      (VSYNC),
    .HREF       (HREF),
    .pshdta     (pshdta),
    .PixParaBus (PixParaBus),
    .Wrtcmplt   (Wrtcmplt),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .frame_start(frame_start),
    .line_end   (line_end),
    .frame_err  (frame_err)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, let one rising edge pass, then sample 1 ns later.
  task automatic tick(input logic v, input logic h, input logic [7:0] d);
    VSYNC  = v;
    HREF   = h;
    pshdta = d;
    @(posedge pclk);
    #1;
  endtask

  task automatic chk_pix(input string tag, input logic [11:0] pix, input int x, input int y);
    chk({tag, ".wr"}, 32'(Wrtcmplt), 32'd1);
    chk({tag, ".pix"}, 32'(PixParaBus), 32'(pix));
    chk({tag, ".x"}, 32'(pix_x), 32'(x));
    chk({tag, ".y"}, 32'(pix_y), 32'(y));
  endtask

  logic [7:0]  line_bytes [12];
  logic [11:0] line_pix   [4];

  initial begin
    line_bytes = '{8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h12, 8'h34,
                   8'h81, 8'h7E, 8'h55, 8'hAA, 8'hFF, 8'h00};
    line_pix   = '{12'hAAD, 12'h391, 12'h14A, 12'h82F};

    rst = 1'b1; VSYNC = 1'b0; HREF = 1'b1; pshdta = 8'hAA;
    tick(0, 1, 8'hAA);
    tick(0, 1, 8'h55);
    chk("rst.pix", 32'(PixParaBus), 32'h0);
    chk("rst.wr", 32'(Wrtcmplt), 32'h0);
    chk("rst.xy", 32'({pix_x, pix_y}), 32'h0);
    chk("rst.flags", 32'({frame_start, line_end, frame_err}), 32'h0);

    // Released mid-line: bytes ignored until a VSYNC high/low cycle.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 8'(8'hF0 + i));
      chk("sync.quiet", 32'({Wrtcmplt, frame_start, line_end}), 32'h0);
    end
    tick(1, 0, 8'h00);
    tick(1, 0, 8'h00);
    chk("blank.nofs", 32'(frame_start), 32'h0);
    tick(0, 0, 8'h00);
    chk("f1.fs", 32'(frame_start), 32'h1);
    tick(0, 0, 8'h00);
    chk("f1.fs_pulse", 32'(frame_start), 32'h0);

    // Frame 1, line 0
    tick(0, 1, 8'hF8);
    chk("l0.b0.wr", 32'(Wrtcmplt), 32'h0);
    tick(0, 1, 8'h00);
    chk_pix("l0.p0", 12'hF00, 0, 0);
    tick(0, 1, 8'h07);
    chk("l0.b2.wr", 32'(Wrtcmplt), 32'h0);
    chk("l0.hold", 32'(PixParaBus), 32'hF00);
    tick(0, 1, 8'hE0);
    chk_pix("l0.p1", 12'h0F0, 1, 0);
    tick(0, 0, 8'h00);
    chk("l0.le", 32'(line_end), 32'h1);
    chk("l0.le.wr", 32'(Wrtcmplt), 32'h0);
    tick(0, 0, 8'h00);
    chk("l0.le_pulse", 32'(line_end), 32'h0);

    // Frame 1, line 1
    tick(0, 1, 8'h00);
    tick(0, 1, 8'h1F);
    chk_pix("l1.p0", 12'h00F, 0, 1);
    tick(0, 1, 8'hFF);
    tick(0, 1, 8'hFF);
    chk_pix("l1.p1", 12'hFFF, 1, 1);
    tick(0, 0, 8'h00);
    chk("l1.le", 32'(line_end), 32'h1);
    chk("l1.err", 32'(frame_err), 32'h0);

    // Frame 1, line 2 is past the line limit
    tick(0, 1, 8'h12);
    chk("l2.err", 32'(frame_err), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 8'h34);
      chk("l2.nowr", 32'(Wrtcmplt), 32'h0);
    end
    tick(0, 0, 8'h00);
    chk("l2.nole", 32'(line_end), 32'h0);

    // Frame 2: five-byte line
    tick(1, 0, 8'h00);
    tick(0, 0, 8'h00);
    chk("f2.fs", 32'(frame_start), 32'h1);
    chk("f2.errclr", 32'(frame_err), 32'h0);
    tick(0, 1, 8'hF8);
    tick(0, 1, 8'h00);
    chk_pix("odd.p0", 12'hF00, 0, 0);
    tick(0, 1, 8'h07);
    tick(0, 1, 8'hE0);
    chk_pix("odd.p1", 12'h0F0, 1, 0);
    tick(0, 1, 8'hFF);
    chk("odd.b4.wr", 32'(Wrtcmplt), 32'h0);
    chk("odd.b4.err", 32'(frame_err), 32'h0);
    tick(0, 0, 8'h00);
    chk("odd.le", 32'(line_end), 32'h1);
    chk("odd.err", 32'(frame_err), 32'h1);
    chk("odd.wr", 32'(Wrtcmplt), 32'h0);

    // Frame 3: 12-byte line against the column limit
    tick(1, 0, 8'h00);
    tick(0, 0, 8'h00);
    chk("f3.fs", 32'(frame_start), 32'h1);
    chk("f3.errclr", 32'(frame_err), 32'h0);
    for (int i = 0; i < 12; i++) begin
      tick(0, 1, line_bytes[i]);
      if ((i % 2 == 1) && (i < 8)) begin
        chk_pix("col.p", line_pix[i/2], i/2, 0);
      end else begin
        chk("col.nowr", 32'(Wrtcmplt), 32'h0);
      end
      chk("col.err", 32'(frame_err), (i >= 9) ? 32'h1 : 32'h0);
    end
    tick(0, 0, 8'h00);
    chk("col.le", 32'(line_end), 32'h1);
    tick(0, 0, 8'h00);
    tick(0, 1, 8'h00);
    tick(0, 1, 8'h1F);
    chk_pix("col.next", 12'h00F, 0, 1);
    tick(0, 0, 8'h00);
    chk("col.next.le", 32'(line_end), 32'h1);

    // Frame 4: VSYNC rises in the middle of a pixel
    tick(1, 0, 8'h00);
    tick(0, 0, 8'h00);
    chk("f4.fs", 32'(frame_start), 32'h1);
    chk("f4.errclr", 32'(frame_err), 32'h0);
    tick(0, 1, 8'h11);
    tick(1, 1, 8'h22);
    chk("vs.nowr", 32'(Wrtcmplt), 32'h0);
    chk("vs.err", 32'(frame_err), 32'h1);
    tick(1, 0, 8'h00);
    tick(0, 0, 8'h00);
    chk("f5.fs", 32'(frame_start), 32'h1);
    chk("f5.errclr", 32'(frame_err), 32'h0);
    tick(0, 1, 8'hFF);
    tick(0, 1, 8'hFF);
    chk_pix("f5.p0", 12'hFFF, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
